mms_ptw: RTL and testbench

//  Sv32 hardware page-table walker: sequences ITLB/DTLB refills in the MMS. Round-robin arbitrates miss requests from both TLBs,

---
 rtl/mms_ptw_pkg.sv | 44 ++++
 rtl/mms_ptw_arb.sv | 32 +++
 rtl/mms_ptw.sv | 225 ++++++++++++++++++++++
 tb/tb_mms_ptw.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mms_ptw_pkg.sv
// mms_ptw_pkg: shared types, widths and PTE decode helpers for the Sv32 page-table walker.
package mms_ptw_pkg;

   localparam int SV32_PTE_WD = 32;
   localparam int PPN_WD      = 22;
   localparam int ASID_WD     = 9;
   localparam int VPN1_WD     = 10;
   localparam int VPN0_WD     = 10;
   localparam int VPN_WD      = VPN1_WD + VPN0_WD;
   localparam int PADDR_WD    = 34;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_L1_REQ  = 3'd1,
      S_L1_WAIT = 3'd2,
      S_L0_REQ  = 3'd3,
      S_L0_WAIT = 3'd4,
      S_RESP    = 3'd5
   } ptw_state_e;

   typedef enum logic {
      DST_ITLB = 1'b0,
      DST_DTLB = 1'b1
   } ptw_dst_e;

   // flags = {D, A, G, U, X, W, R, V}
   typedef struct packed {
      logic [11:0] ppn1;
      logic [9:0]  ppn0;
      logic [1:0]  rsw;
      logic [7:0]  flags;
   } sv32_pte_t;

   // Invalid entry, or the reserved write-without-read encoding.
   function automatic logic pte_fault(input sv32_pte_t p);
      return !p.flags[0] || (!p.flags[1] && p.flags[2]);
   endfunction

   // Any of R or X marks a leaf; otherwise the entry points to the next level.
   function automatic logic pte_leaf(input sv32_pte_t p);
      return p.flags[1] || p.flags[3];
   endfunction

endpackage

// File: rtl/mms_ptw_arb.sv
// mms_ptw_arb: 2-way round-robin arbiter between ITLB (req[0]) and DTLB (req[1]) misses.
module mms_ptw_arb
   import mms_ptw_pkg::*;
#(
   parameter int RR_INIT = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       en,
   output logic [1:0] gnt
);

   // ptr = side that wins when both request (0 = ITLB, 1 = DTLB)
   logic ptr;

   // Grant: a lone requester always wins; a tie goes to the pointer side.
   always_comb begin
      gnt = 2'b00;
      if (en) begin
         if (req == 2'b11) gnt = ptr ? 2'b10 : 2'b01;
         else              gnt = req;
      end
   end

   // Pointer moves to the side that was not just granted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      ptr <= (RR_INIT != 0);
      else if (|gnt)   ptr <= gnt[DST_ITLB];
   end

endmodule

// File: rtl/mms_ptw.sv
// mms_ptw: Sv32 hardware page-table walker serving ITLB/DTLB refills, one walk at a time.
// Optional feature macro: MMS_PTW_L1_CACHE_EN -- one-entry cache of the last level-1
// pointer PTE so a repeat walk in the same 4 MiB region skips the level-1 read.
module mms_ptw
   import mms_ptw_pkg::*;
#(
   parameter int PTE_WD  = SV32_PTE_WD,
   parameter int RR_INIT = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [PPN_WD-1:0]   satp_ppn_i,
   input  logic [ASID_WD-1:0]  satp_asid_i,
   input  logic                flush_i,
   input  logic                itlb_req_vld_i,
   input  logic [VPN_WD-1:0]   itlb_req_vpn_i,
   output logic                itlb_req_rdy_o,
   input  logic                dtlb_req_vld_i,
   input  logic [VPN_WD-1:0]   dtlb_req_vpn_i,
   output logic                dtlb_req_rdy_o,
   output logic                mem_req_vld_o,
   output logic [PADDR_WD-1:0] mem_req_addr_o,
   input  logic                mem_req_rdy_i,
   input  logic                mem_rsp_vld_i,
   input  logic [PTE_WD-1:0]   mem_rsp_data_i,
   output logic                resp_vld_o,
   output logic                resp_dst_o,
   output logic [VPN_WD-1:0]   resp_vpn_o,
   output logic [ASID_WD-1:0]  resp_asid_o,
   output logic [PTE_WD-1:0]   resp_pte_o,
   output logic                resp_super_o,
   output logic                resp_fault_o
);

   ptw_state_e         state;
   logic [VPN_WD-1:0]  vpn_q;
   logic [ASID_WD-1:0] asid_q;
   logic               dst_q;
   logic               kill_q;

   logic [1:0]         gnt;
   logic               grant;
   logic [VPN_WD-1:0]  gnt_vpn;

   sv32_pte_t          pte;
   logic [PPN_WD-1:0]  pte_ppn;
   logic               pte_bad;
   logic               pte_is_leaf;
   logic               pte_misal;

   logic               hit;
   logic [PPN_WD-1:0]  hit_ppn;

   // Requests are only considered while idle, so rdy never rises mid-walk or in RESP.
   mms_ptw_arb #(.RR_INIT(RR_INIT)) u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   ({dtlb_req_vld_i, itlb_req_vld_i}),
      .en    (state == S_IDLE),
      .gnt   (gnt)
   );

   assign itlb_req_rdy_o = gnt[DST_ITLB];
   assign dtlb_req_rdy_o = gnt[DST_DTLB];
   assign grant          = |gnt;
   assign gnt_vpn        = gnt[DST_DTLB] ? dtlb_req_vpn_i : itlb_req_vpn_i;

   assign pte         = sv32_pte_t'(mem_rsp_data_i[SV32_PTE_WD-1:0]);
   assign pte_ppn     = {pte.ppn1, pte.ppn0};
   assign pte_bad     = pte_fault(pte);
   assign pte_is_leaf = pte_leaf(pte);
   assign pte_misal   = |pte.ppn0;

`ifdef MMS_PTW_L1_CACHE_EN
   logic               c_vld;
   logic [ASID_WD-1:0] c_asid;
   logic [VPN1_WD-1:0] c_vpn1;
   logic [PPN_WD-1:0]  c_ppn;
   logic               fill;

   // Only a good pointer PTE from a walk that is not being killed is worth keeping.
   assign fill    = (state == S_L1_WAIT) && mem_rsp_vld_i && !kill_q && !flush_i &&
                    !pte_bad && !pte_is_leaf;
   assign hit     = c_vld && (c_asid == satp_asid_i) &&
                    (c_vpn1 == gnt_vpn[VPN_WD-1:VPN0_WD]);
   assign hit_ppn = c_ppn;

   // Cache entry: sfence.vma drops it, otherwise refilled on every level-1 pointer PTE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_vld  <= 1'b0;
         c_asid <= '0;
         c_vpn1 <= '0;
         c_ppn  <= '0;
      end else if (flush_i) begin
         c_vld  <= 1'b0;
      end else if (fill) begin
         c_vld  <= 1'b1;
         c_asid <= asid_q;
         c_vpn1 <= vpn_q[VPN_WD-1:VPN0_WD];
         c_ppn  <= pte_ppn;
      end
   end
`else
   assign hit     = 1'b0;
   assign hit_ppn = '0;
`endif

   // Walk FSM; every memory and response output is registered here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         mem_req_vld_o  <= 1'b0;
         mem_req_addr_o <= '0;
         vpn_q          <= '0;
         asid_q         <= '0;
         dst_q          <= 1'b0;
         kill_q         <= 1'b0;
         resp_vld_o     <= 1'b0;
         resp_dst_o     <= 1'b0;
         resp_vpn_o     <= '0;
         resp_asid_o    <= '0;
         resp_pte_o     <= '0;
         resp_super_o   <= 1'b0;
         resp_fault_o   <= 1'b0;
      end else begin
         // Response fields are only meaningful in the RESP cycle; zero them otherwise.
         resp_vld_o   <= 1'b0;
         resp_dst_o   <= 1'b0;
         resp_vpn_o   <= '0;
         resp_asid_o  <= '0;
         resp_pte_o   <= '0;
         resp_super_o <= 1'b0;
         resp_fault_o <= 1'b0;

         case (state)
            S_IDLE: begin
               if (grant) begin
                  vpn_q  <= gnt_vpn;
                  asid_q <= satp_asid_i;
                  dst_q  <= gnt[DST_DTLB];
                  if (flush_i) begin
                     // Requester sees its grant, but the walk dies before any read.
                     state <= S_IDLE;
                  end else if (hit) begin
                     state          <= S_L0_REQ;
                     mem_req_vld_o  <= 1'b1;
                     mem_req_addr_o <= {hit_ppn, gnt_vpn[VPN0_WD-1:0], 2'b00};
                  end else begin
                     state          <= S_L1_REQ;
                     mem_req_vld_o  <= 1'b1;
                     mem_req_addr_o <= {satp_ppn_i, gnt_vpn[VPN_WD-1:VPN0_WD], 2'b00};
                  end
               end
            end

            S_L1_REQ, S_L0_REQ: begin
               if (mem_req_rdy_i) begin
                  // Once accepted a read must be drained, so a flush here becomes a kill.
                  mem_req_vld_o <= 1'b0;
                  kill_q        <= flush_i;
                  state         <= (state == S_L1_REQ) ? S_L1_WAIT : S_L0_WAIT;
               end else if (flush_i) begin
                  mem_req_vld_o <= 1'b0;
                  state         <= S_IDLE;
               end
            end

            S_L1_WAIT: begin
               if (mem_rsp_vld_i) begin
                  if (kill_q || flush_i) begin
                     kill_q <= 1'b0;
                     state  <= S_IDLE;
                  end else if (pte_bad || (pte_is_leaf && pte_misal)) begin
                     state        <= S_RESP;
                     resp_vld_o   <= 1'b1;
                     resp_dst_o   <= dst_q;
                     resp_vpn_o   <= vpn_q;
                     resp_asid_o  <= asid_q;
                     resp_fault_o <= 1'b1;
                  end else if (pte_is_leaf) begin
                     state        <= S_RESP;
                     resp_vld_o   <= 1'b1;
                     resp_dst_o   <= dst_q;
                     resp_vpn_o   <= vpn_q;
                     resp_asid_o  <= asid_q;
                     resp_pte_o   <= PTE_WD'(pte);
                     resp_super_o <= 1'b1;
                  end else begin
                     state          <= S_L0_REQ;
                     mem_req_vld_o  <= 1'b1;
                     mem_req_addr_o <= {pte_ppn, vpn_q[VPN0_WD-1:0], 2'b00};
                  end
               end else if (flush_i) begin
                  kill_q <= 1'b1;
               end
            end

            S_L0_WAIT: begin
               if (mem_rsp_vld_i) begin
                  if (kill_q || flush_i) begin
                     kill_q <= 1'b0;
                     state  <= S_IDLE;
                  end else begin
                     // A pointer at level 0 has nowhere left to go: fault.
                     state        <= S_RESP;
                     resp_vld_o   <= 1'b1;
                     resp_dst_o   <= dst_q;
                     resp_vpn_o   <= vpn_q;
                     resp_asid_o  <= asid_q;
                     if (pte_bad || !pte_is_leaf) resp_fault_o <= 1'b1;
                     else                         resp_pte_o   <= PTE_WD'(pte);
                  end
               end else if (flush_i) begin
                  kill_q <= 1'b1;
               end
            end

            S_RESP:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mms_ptw.sv
// tb_mms_ptw: directed self-checking bench for the Sv32 page-table walker.
// Also valid with MMS_PTW_L1_CACHE_EN defined (cache-specific expectations switch).
module tb_mms_ptw;

   logic        clk;
   logic        rst_n;
   logic [21:0] satp_ppn_i;
   logic [8:0]  satp_asid_i;
   logic        flush_i;
   logic        itlb_req_vld_i;
   logic [19:0] itlb_req_vpn_i;
   logic        itlb_req_rdy_o;
   logic        dtlb_req_vld_i;
   logic [19:0] dtlb_req_vpn_i;
   logic        dtlb_req_rdy_o;
   logic        mem_req_vld_o;
   logic [33:0] mem_req_addr_o;
   logic        mem_req_rdy_i;
   logic        mem_rsp_vld_i;
   logic [31:0] mem_rsp_data_i;
   logic        resp_vld_o;
   logic        resp_dst_o;
   logic [19:0] resp_vpn_o;
   logic [8:0]  resp_asid_o;
   logic [31:0] resp_pte_o;
   logic        resp_super_o;
   logic        resp_fault_o;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int gcyc = 0;
   int resp_cnt = 0;
   int r0;

   mms_ptw #(.PTE_WD(32), .RR_INIT(0)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .satp_ppn_i     (satp_ppn_i),
      .satp_asid_i    (satp_asid_i),
      .flush_i        (flush_i),
      .itlb_req_vld_i (itlb_req_vld_i),
      .itlb_req_vpn_i (itlb_req_vpn_i),
      .itlb_req_rdy_o (itlb_req_rdy_o),
      .dtlb_req_vld_i (dtlb_req_vld_i),
      .dtlb_req_vpn_i (dtlb_req_vpn_i),
      .dtlb_req_rdy_o (dtlb_req_rdy_o),
      .mem_req_vld_o  (mem_req_vld_o),
      .mem_req_addr_o (mem_req_addr_o),
      .mem_req_rdy_i  (mem_req_rdy_i),
      .mem_rsp_vld_i  (mem_rsp_vld_i),
      .mem_rsp_data_i (mem_rsp_data_i),
      .resp_vld_o     (resp_vld_o),
      .resp_dst_o     (resp_dst_o),
      .resp_vpn_o     (resp_vpn_o),
      .resp_asid_o    (resp_asid_o),
      .resp_pte_o     (resp_pte_o),
      .resp_super_o   (resp_super_o),
      .resp_fault_o   (resp_fault_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (resp_vld_o) resp_cnt <= resp_cnt + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One idle flush cycle: drops any cached level-1 entry so tests stay independent.
   task automatic inval();
      flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
   endtask

   task automatic start(input logic d, input logic [19:0] vpn, input bit inv, input string tag);
      if (inv) inval();
      if (d) begin dtlb_req_vld_i = 1'b1; dtlb_req_vpn_i = vpn; end
      else   begin itlb_req_vld_i = 1'b1; itlb_req_vpn_i = vpn; end
      #1;
      chk({tag, " rdy"}, d ? dtlb_req_rdy_o : itlb_req_rdy_o, 1'b1);
      gcyc = cyc;
      @(negedge clk);
      itlb_req_vld_i = 1'b0;
      dtlb_req_vld_i = 1'b0;
   endtask

   // Zero-wait memory: accept immediately, return data the next cycle.
   task automatic mem_read(input logic [33:0] addr, input logic [31:0] data, input string tag);
      int n = 0;
      while (!mem_req_vld_o && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, " req"}, mem_req_vld_o, 1'b1);
      chk({tag, " addr"}, mem_req_addr_o, addr);
      mem_req_rdy_i = 1'b1;
      @(negedge clk);
      mem_req_rdy_i  = 1'b0;
      mem_rsp_vld_i  = 1'b1;
      mem_rsp_data_i = data;
      @(negedge clk);
      mem_rsp_vld_i  = 1'b0;
      mem_rsp_data_i = 32'h0;
   endtask

   task automatic expect_resp(input string tag, input logic d, input logic [19:0] vpn,
                              input logic [8:0] asid, input logic [31:0] pte,
                              input logic sup, input logic flt, input int lat);
      chk({tag, " vld"},   resp_vld_o,   1'b1);
      chk({tag, " dst"},   resp_dst_o,   d);
      chk({tag, " vpn"},   resp_vpn_o,   vpn);
      chk({tag, " asid"},  resp_asid_o,  asid);
      chk({tag, " pte"},   resp_pte_o,   pte);
      chk({tag, " super"}, resp_super_o, sup);
      chk({tag, " fault"}, resp_fault_o, flt);
      chk({tag, " lat"},   cyc - gcyc,   lat);
      chk({tag, " memidle"}, mem_req_vld_o, 1'b0);
      @(negedge clk);
      chk({tag, " pulse"}, resp_vld_o, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      satp_ppn_i = 22'h100;
      satp_asid_i = 9'h005;
      flush_i = 1'b0;
      itlb_req_vld_i = 1'b0;
      itlb_req_vpn_i = 20'h0;
      dtlb_req_vld_i = 1'b0;
      dtlb_req_vpn_i = 20'h0;
      mem_req_rdy_i = 1'b0;
      mem_rsp_vld_i = 1'b0;
      mem_rsp_data_i = 32'h0;

      // Reset state
      @(negedge clk);
      chk("rst memvld", mem_req_vld_o, 1'b0);
      chk("rst addr", mem_req_addr_o, 34'h0);
      chk("rst respvld", resp_vld_o, 1'b0);
      chk("rst pte", resp_pte_o, 32'h0);
      chk("rst vpn", resp_vpn_o, 20'h0);
      chk("rst irdy", itlb_req_rdy_o, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);

      // ITLB 4 KiB walk
      start(1'b0, 20'h00401, 1'b1, "i4k");
      mem_read(34'h0_0010_0004, 32'h0008_0001, "i4k l1");
      mem_read(34'h0_0020_0004, 32'h0000_040F, "i4k l0");
      expect_resp("i4k", 1'b0, 20'h00401, 9'h005, 32'h0000_040F, 1'b0, 1'b0, 5);

      // DTLB superpage: one read
      start(1'b1, 20'h00401, 1'b1, "dsup");
      mem_read(34'h0_0010_0004, 32'h2000_000F, "dsup l1");
      expect_resp("dsup", 1'b1, 20'h00401, 9'h005, 32'h2000_000F, 1'b1, 1'b0, 3);

      // Misaligned superpage
      start(1'b1, 20'h00401, 1'b1, "misal");
      mem_read(34'h0_0010_0004, 32'h0000_040F, "misal l1");
      expect_resp("misal", 1'b1, 20'h00401, 9'h005, 32'h0, 1'b0, 1'b1, 3);

      // Invalid L1 PTE
      start(1'b0, 20'h12345, 1'b1, "inv");
      mem_read(34'h0_0010_0120, 32'h0, "inv l1");
      expect_resp("inv", 1'b0, 20'h12345, 9'h005, 32'h0, 1'b0, 1'b1, 3);

      // W without R
      start(1'b0, 20'h00401, 1'b1, "wnr");
      mem_read(34'h0_0010_0004, 32'h0000_0005, "wnr l1");
      expect_resp("wnr", 1'b0, 20'h00401, 9'h005, 32'h0, 1'b0, 1'b1, 3);

      // Pointer at level 0
      start(1'b1, 20'h00401, 1'b1, "l0ptr");
      mem_read(34'h0_0010_0004, 32'h0008_0001, "l0ptr l1");
      mem_read(34'h0_0020_0004, 32'h0008_0001, "l0ptr l0");
      expect_resp("l0ptr", 1'b1, 20'h00401, 9'h005, 32'h0, 1'b0, 1'b1, 5);

      // satp changes after grant do not affect the walk
      start(1'b0, 20'h00401, 1'b1, "satp");
      satp_ppn_i = 22'h3FF;
      satp_asid_i = 9'h1AA;
      mem_read(34'h0_0010_0004, 32'h0008_0001, "satp l1");
      mem_read(34'h0_0020_0004, 32'h0000_040F, "satp l0");
      expect_resp("satp", 1'b0, 20'h00401, 9'h005, 32'h0000_040F, 1'b0, 1'b0, 5);
      satp_ppn_i = 22'h100;
      satp_asid_i = 9'h005;

      // Async reset mid-walk, then a stray response in IDLE
      start(1'b0, 20'h00401, 1'b1, "rstmid");
      mem_req_rdy_i = 1'b1;
      @(negedge clk);
      mem_req_rdy_i = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("rstmid memvld", mem_req_vld_o, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      r0 = resp_cnt;
      mem_rsp_vld_i = 1'b1;
      mem_rsp_data_i = 32'h0000_040F;
      @(negedge clk);
      mem_rsp_vld_i = 1'b0;
      mem_rsp_data_i = 32'h0;
      repeat (3) @(negedge clk);
      #1;
      chk("stray resp", resp_cnt, r0);
      chk("stray memvld", mem_req_vld_o, 1'b0);
      @(negedge clk);

      // Round robin from reset pointer (ITLB first)
      itlb_req_vld_i = 1'b1; itlb_req_vpn_i = 20'h00401;
      dtlb_req_vld_i = 1'b1; dtlb_req_vpn_i = 20'h00801;
      #1;
      chk("arb1 irdy", itlb_req_rdy_o, 1'b1);
      chk("arb1 drdy", dtlb_req_rdy_o, 1'b0);
      gcyc = cyc;
      @(negedge clk);
      itlb_req_vld_i = 1'b0;
      mem_read(34'h0_0010_0004, 32'h2000_000F, "arb1 l1");
      chk("arb resp nogrant", dtlb_req_rdy_o, 1'b0);
      expect_resp("arb1", 1'b0, 20'h00401, 9'h005, 32'h2000_000F, 1'b1, 1'b0, 3);
      chk("arb2 drdy", dtlb_req_rdy_o, 1'b1);
      gcyc = cyc;
      @(negedge clk);
      dtlb_req_vld_i = 1'b0;
      mem_read(34'h0_0010_0008, 32'h2000_000F, "arb2 l1");
      expect_resp("arb2", 1'b1, 20'h00801, 9'h005, 32'h2000_000F, 1'b1, 1'b0, 3);
      itlb_req_vld_i = 1'b1;
      dtlb_req_vld_i = 1'b1;
      #1;
      chk("arb3 irdy", itlb_req_rdy_o, 1'b1);
      chk("arb3 drdy", dtlb_req_rdy_o, 1'b0);
      gcyc = cyc;
      @(negedge clk);
      itlb_req_vld_i = 1'b0;
      dtlb_req_vld_i = 1'b0;
      mem_read(34'h0_0010_0004, 32'h2000_000F, "arb3 l1");
      expect_resp("arb3", 1'b0, 20'h00401, 9'h005, 32'h2000_000F, 1'b1, 1'b0, 3);

      // Flush during L1_WAIT: response 3 cycles later is swallowed
      start(1'b0, 20'h00401, 1'b1, "fwait");
      r0 = resp_cnt;
      mem_req_rdy_i = 1'b1;
      @(negedge clk);
      mem_req_rdy_i = 1'b0;
      flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
      repeat (2) @(negedge clk);
      mem_rsp_vld_i = 1'b1;
      mem_rsp_data_i = 32'h0000_040F;
      @(negedge clk);
      mem_rsp_vld_i = 1'b0;
      mem_rsp_data_i = 32'h0;
      repeat (2) @(negedge clk);
      #1;
      chk("fwait noresp", resp_cnt, r0);
      chk("fwait memvld", mem_req_vld_o, 1'b0);
      start(1'b1, 20'h00401, 1'b1, "fwait next");
      mem_read(34'h0_0010_0004, 32'h2000_000F, "fwait next l1");
      expect_resp("fwait next", 1'b1, 20'h00401, 9'h005, 32'h2000_000F, 1'b1, 1'b0, 3);

      // Flush during L1_REQ drops the request
      start(1'b0, 20'h00401, 1'b1, "freq");
      r0 = resp_cnt;
      chk("freq vld", mem_req_vld_o, 1'b1);
      flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
      chk("freq drop", mem_req_vld_o, 1'b0);
      repeat (3) @(negedge clk);
      #1;
      chk("freq noresp", resp_cnt, r0);
      chk("freq idle", mem_req_vld_o, 1'b0);
      @(negedge clk);

      // Flush on the grant cycle: grant stands, walk dies
      r0 = resp_cnt;
      itlb_req_vld_i = 1'b1; itlb_req_vpn_i = 20'h00401;
      flush_i = 1'b1;
      #1;
      chk("fgnt rdy", itlb_req_rdy_o, 1'b1);
      @(negedge clk);
      itlb_req_vld_i = 1'b0;
      flush_i = 1'b0;
      chk("fgnt memvld", mem_req_vld_o, 1'b0);
      repeat (3) @(negedge clk);
      #1;
      chk("fgnt noresp", resp_cnt, r0);
      @(negedge clk);

      // Memory back-pressure: request held stable for 10 cycles
      start(1'b1, 20'h12345, 1'b1, "bp");
      for (int i = 0; i < 10; i++) begin
         chk("bp vld", mem_req_vld_o, 1'b1);
         chk("bp addr", mem_req_addr_o, 34'h0_0010_0120);
         @(negedge clk);
      end
      mem_read(34'h0_0010_0120, 32'h0008_0001, "bp l1");
      mem_read(34'h0_0020_0D14, 32'h1234_5C0F, "bp l0");
      expect_resp("bp", 1'b1, 20'h12345, 9'h005, 32'h1234_5C0F, 1'b0, 1'b0, 15);

      // Level-1 cache behaviour
      start(1'b0, 20'h00401, 1'b1, "c1");
      mem_read(34'h0_0010_0004, 32'h0008_0001, "c1 l1");
      mem_read(34'h0_0020_0004, 32'h0000_040F, "c1 l0");
      expect_resp("c1", 1'b0, 20'h00401, 9'h005, 32'h0000_040F, 1'b0, 1'b0, 5);
      start(1'b1, 20'h00402, 1'b0, "c2");
`ifdef MMS_PTW_L1_CACHE_EN
      mem_read(34'h0_0020_0008, 32'h0000_040F, "c2 l0");
      expect_resp("c2", 1'b1, 20'h00402, 9'h005, 32'h0000_040F, 1'b0, 1'b0, 3);
`else
      mem_read(34'h0_0010_0004, 32'h0008_0001, "c2 l1");
      mem_read(34'h0_0020_0008, 32'h0000_040F, "c2 l0");
      expect_resp("c2", 1'b1, 20'h00402, 9'h005, 32'h0000_040F, 1'b0, 1'b0, 5);
`endif
      start(1'b1, 20'h00402, 1'b1, "c3");
      mem_read(34'h0_0010_0004, 32'h0008_0001, "c3 l1");
      mem_read(34'h0_0020_0008, 32'h0000_040F, "c3 l0");
      expect_resp("c3", 1'b1, 20'h00402, 9'h005, 32'h0000_040F, 1'b0, 1'b0, 5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
